// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared Y86-64 pipeline constants, payload layouts and bubble defaults
package pipe_stage_reg_pkg;

  // Status field shared by every stage register
  localparam int STAT_W = 2;

  typedef enum logic [STAT_W-1:0] {
    SAOK = 2'd0,
    SADR = 2'd1,
    SINS = 2'd2,
    SHLT = 2'd3
  } stat_e;

  // Instruction codes
  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  // Register id meaning "no register"
  localparam logic [3:0] RNONE = 4'hF;

  // Packed payload widths per stage boundary
  localparam int F_PAYLOAD_W = 64;
  localparam int D_PAYLOAD_W = 144;
  localparam int E_PAYLOAD_W = 216;
  localparam int M_PAYLOAD_W = 141;
  localparam int W_PAYLOAD_W = 140;

  // Fetch -> decode payload
  typedef struct packed {
    icode_e      icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_payload_t;

  // Decode -> execute payload
  typedef struct packed {
    icode_e      icode;
    logic [3:0]  ifun;
    logic [63:0] valc;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [3:0]  srca;
    logic [3:0]  srcb;
  } e_payload_t;

  // Execute -> memory payload
  typedef struct packed {
    icode_e      icode;
    logic        cnd;
    logic [63:0] vale;
    logic [63:0] vala;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } m_payload_t;

  // Memory -> writeback payload
  typedef struct packed {
    icode_e      icode;
    logic [63:0] vale;
    logic [63:0] valm;
    logic [3:0]  dste;
    logic [3:0]  dstm;
  } w_payload_t;

  // Bubble payloads: icode 0 everywhere, and no destination register downstream of decode
  localparam logic [F_PAYLOAD_W-1:0] F_BUBBLE_DATA = '0;
  localparam logic [D_PAYLOAD_W-1:0] D_BUBBLE_DATA = '0;
  localparam e_payload_t E_BUBBLE_DATA = '{
    icode: IHALT, ifun: 4'h0, valc: 64'h0, vala: 64'h0, valb: 64'h0,
    dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
  };
  localparam m_payload_t M_BUBBLE_DATA = '{
    icode: IHALT, cnd: 1'b0, vale: 64'h0, vala: 64'h0, dste: RNONE, dstm: RNONE
  };
  localparam w_payload_t W_BUBBLE_DATA = '{
    icode: IHALT, vale: 64'h0, valm: 64'h0, dste: RNONE, dstm: RNONE
  };

  // Build a decode-stage payload from its fields
  function automatic logic [D_PAYLOAD_W-1:0] pack_d(
    input icode_e      icode,
    input logic [3:0]  ifun,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [63:0] valc,
    input logic [63:0] valp
  );
    d_payload_t p;
    p.icode = icode;
    p.ifun  = ifun;
    p.ra    = ra;
    p.rb    = rb;
    p.valc  = valc;
    p.valp  = valp;
    return p;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream slot bundle of a pipeline boundary register
interface pipe_stage_reg_if #(
  parameter int DATA_W = pipe_stage_reg_pkg::D_PAYLOAD_W,
  parameter int STAT_W = pipe_stage_reg_pkg::STAT_W
);
  logic              stall;
  logic              bubble;
  logic              in_valid;
  logic [STAT_W-1:0] in_stat;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [STAT_W-1:0] out_stat;
  logic [DATA_W-1:0] out_data;

  // Hazard unit / upstream stage side
  modport master (
    output stall, bubble, in_valid, in_stat, in_data,
    input  out_valid, out_stat, out_data
  );

  // Boundary register side
  modport slave (
    input  stall, bubble, in_valid, in_stat, in_data,
    output out_valid, out_stat, out_data
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins over increment; the count sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline boundary register with stall/bubble counters
module pipe_stage_reg #(
  parameter int                DATA_W      = pipe_stage_reg_pkg::D_PAYLOAD_W,
  parameter int                STAT_W      = pipe_stage_reg_pkg::STAT_W,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = '0,
  parameter logic [STAT_W-1:0] BUBBLE_STAT = STAT_W'(pipe_stage_reg_pkg::SAOK),
  parameter int                CNT_W       = 16,
  parameter int                STALL_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  pipe_stage_reg_if.slave   bus,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_run,
  output logic              stall_timeout
);
  import pipe_stage_reg_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  // A stall only counts when no bubble overrides it
  logic eff_stall;
  assign eff_stall = bus.stall & ~bus.bubble;

  // Slot update: reset and bubble both inject the bubble values, stall holds, otherwise load
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_stat  <= BUBBLE_STAT;
      bus.out_data  <= BUBBLE_DATA;
    end else if (bus.bubble) begin
      bus.out_valid <= 1'b0;
      bus.out_stat  <= BUBBLE_STAT;
      bus.out_data  <= BUBBLE_DATA;
    end else if (!bus.stall) begin
      bus.out_valid <= bus.in_valid;
      bus.out_stat  <= bus.in_stat;
      bus.out_data  <= bus.in_data;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (eff_stall),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt),
    .inc (bus.bubble),
    .cnt (bubble_cnt)
  );

  // The run length restarts on every edge that is not an effective stall
  sat_counter #(.CNT_W(CNT_W)) u_stall_run (
    .clk (clk),
    .rst (rst),
    .clr (clr_cnt | ~eff_stall),
    .inc (eff_stall),
    .cnt (stall_run)
  );

  // Watchdog lags stall_run by one edge and drops on the same edge the run clears
  always_ff @(posedge clk) begin
    if (rst || clr_cnt || !eff_stall) begin
      stall_timeout <= 1'b0;
    end else begin
      stall_timeout <= (stall_run >= LIMIT);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int DW = 144;
  localparam int SW = 2;
  localparam int CW = 3;

  localparam logic [DW-1:0] DAB = 144'hAB;
  localparam logic [DW-1:0] DA  = 144'h1111_2222_3333_4444_5555_6666_7777_8888_9999;
  localparam logic [DW-1:0] DB  = 144'hBBBB_0000_CCCC_0000_DDDD_0000_EEEE_0000_FFFF;
  localparam logic [DW-1:0] DC  = 144'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF_0123;
  localparam logic [DW-1:0] Z   = '0;

  logic clk = 1'b0;
  logic rst;
  logic clr_cnt;
  logic [CW-1:0] stall_cnt, bubble_cnt, stall_run;
  logic stall_timeout;

  pipe_stage_reg_if #(.DATA_W(DW), .STAT_W(SW)) bus ();

  pipe_stage_reg #(
    .DATA_W(DW), .STAT_W(SW), .BUBBLE_DATA('0), .BUBBLE_STAT(2'd0),
    .CNT_W(CW), .STALL_LIMIT(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .clr_cnt       (clr_cnt),
    .stall_cnt     (stall_cnt),
    .bubble_cnt    (bubble_cnt),
    .stall_run     (stall_run),
    .stall_timeout (stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            idx;
    logic          v;
    logic [SW-1:0] st;
    logic [DW-1:0] d;
    logic [CW-1:0] sc;
    logic [CW-1:0] bc;
    logic [CW-1:0] run;
    logic          to;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   step_no = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, expv);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next rising edge
  task automatic step(
    input logic r, input logic s, input logic b, input logic c,
    input logic v, input logic [SW-1:0] st, input logic [DW-1:0] d,
    input logic ev, input logic [SW-1:0] est, input logic [DW-1:0] ed,
    input int esc, input int ebc, input int erun, input logic eto
  );
    exp_t e;
    @(negedge clk);
    rst = r; bus.stall = s; bus.bubble = b; clr_cnt = c;
    bus.in_valid = v; bus.in_stat = st; bus.in_data = d;
    e.idx = step_no; e.v = ev; e.st = est; e.d = ed;
    e.sc = CW'(esc); e.bc = CW'(ebc); e.run = CW'(erun); e.to = eto;
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: compare the registered outputs just after each edge that has an expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_valid", e.idx, DW'(bus.out_valid), DW'(e.v));
        chk("out_stat", e.idx, DW'(bus.out_stat), DW'(e.st));
        chk("out_data", e.idx, bus.out_data, e.d);
        chk("stall_cnt", e.idx, DW'(stall_cnt), DW'(e.sc));
        chk("bubble_cnt", e.idx, DW'(bubble_cnt), DW'(e.bc));
        chk("stall_run", e.idx, DW'(stall_run), DW'(e.run));
        chk("stall_timeout", e.idx, DW'(stall_timeout), DW'(e.to));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: stimulus did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; clr_cnt = 1'b0;
    bus.stall = 1'b0; bus.bubble = 1'b0;
    bus.in_valid = 1'b0; bus.in_stat = '0; bus.in_data = '0;

    // Reset with unknown controls, then load
    step(1, 1'bx, 1'bx, 0, 1, 2'd1, DA,  0, 0, Z, 0, 0, 0, 0);
    step(1, 1'bx, 1'bx, 0, 1, 2'd1, DA,  0, 0, Z, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2'd0, DAB, 1, 0, DAB, 0, 0, 0, 0);

    // Stall hold for 5 cycles while upstream changes
    step(0, 0, 0, 0, 1, 2'd1, DA,  1, 1, DA, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      step(0, 1, 0, 0, 0, 2'd2, DW'(144'hF0 + i), 1, 1, DA, i, 0, i, (i >= 5));
    step(0, 0, 0, 0, 1, 2'd0, DB,  1, 0, DB, 5, 0, 0, 0);

    // Bubble overrides stall
    step(0, 1, 1, 0, 1, 2'd1, DA,  0, 0, Z, 5, 1, 0, 0);
    step(0, 0, 0, 0, 1, 2'd1, DA,  1, 1, DA, 5, 1, 0, 0);
    step(0, 1, 0, 0, 1, 2'd2, DC,  1, 1, DA, 6, 1, 1, 0);
    step(0, 1, 1, 0, 1, 2'd2, DC,  0, 0, Z, 6, 2, 0, 0);

    // Clear counters on a load edge
    step(0, 0, 0, 1, 1, 2'd2, DB,  1, 2, DB, 0, 0, 0, 0);

    // Watchdog with limit 4 over a 6-cycle stall
    for (int k = 1; k <= 6; k++)
      step(0, 1, 0, 0, 1, 2'd3, DW'(144'h500 + k), 1, 2, DB, k, 0, k, (k >= 5));
    step(0, 0, 0, 0, 0, 2'd1, DC,  0, 1, DC, 6, 0, 0, 0);

    // Clear during stall, then saturation over 10 stall cycles
    step(0, 1, 0, 1, 1, 2'd0, DA,  0, 1, DC, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++)
      step(0, 1, 0, 0, 1, 2'd0, DA, 0, 1, DC, (k > 7) ? 7 : k, 0, (k > 7) ? 7 : k, (k >= 5));
    step(0, 1, 0, 1, 1, 2'd0, DA,  0, 1, DC, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 2'd0, DA,  0, 1, DC, 1, 0, 1, 0);

    // Reset mid-stall loses held data, next load is normal
    step(1, 1, 0, 0, 1, 2'd2, DB,  0, 0, Z, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2'd3, DAB, 1, 3, DAB, 0, 0, 0, 0);
    step(1, 1'bx, 1'bx, 1, 1, 2'd3, DA, 0, 0, Z, 0, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0; bus.stall = 1'b1; bus.bubble = 1'b0; clr_cnt = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised Y86-64 pipeline boundary register.
- Successor to the fixed-field per-stage registers (F/D/E/M/W); one instance per stage boundary.
- Carries a packed payload, a status field and a valid bit, with prioritised reset/bubble/stall control.
- Adds built-in stall/bubble performance counters and a stall-watchdog flag used by the hazard unit and the testbench.

Parameters:
- DATA_W, 144, packed payload width (icode, ifun, rA, rB, valC, valP for the D stage).
- STAT_W, 2, status field width.
- BUBBLE_DATA, 0, payload value loaded on bubble or reset (icode field 0 in D layout).
- BUBBLE_STAT, 0, status value loaded on bubble or reset (SAOK encoding).
- CNT_W, 16, width of each performance counter.
- STALL_LIMIT, 64, consecutive stall cycles at which stall_timeout asserts; legal range 1 .. 2^CNT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold current contents.
- bubble  in  1  load bubble; overrides stall.
- in_valid  in  1  upstream slot holds a real instruction.
- in_stat  in  STAT_W  upstream status.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  registered valid.
- out_stat  out  STAT_W  registered status.
- out_data  out  DATA_W  registered payload.
- stall_cnt  out  CNT_W  total cycles with stall=1 and bubble=0, saturating.
- bubble_cnt  out  CNT_W  total cycles with bubble=1, saturating.
- stall_run  out  CNT_W  current consecutive effective-stall length, saturating.
- stall_timeout  out  1  stall_run >= STALL_LIMIT.
- clr_cnt  in  1  synchronous clear of stall_cnt, bubble_cnt and stall_run.

Behaviour:
- All state updates on the rising edge of clk. Outputs are registered; load-to-output latency is 1 cycle.
- Update priority per edge: rst > bubble > stall > load.
- rst=1:
  - out_valid=0, out_stat=BUBBLE_STAT, out_data=BUBBLE_DATA.
  - All counters 0; stall_timeout=0.
  - rst overrides clr_cnt and all other inputs.
- bubble=1 (any stall value): out_valid=0, out_stat=BUBBLE_STAT, out_data=BUBBLE_DATA.
- stall=1, bubble=0: all three outputs hold their previous values.
- Otherwise (load): out_valid<=in_valid, out_stat<=in_stat, out_data<=in_data.
- in_valid=0 on load: payload and stat are still captured; out_valid=0 marks the slot as a bubble.
- Counter update, per non-reset edge:
  - stall_cnt +1 when stall & ~bubble.
  - bubble_cnt +1 when bubble.
  - Both saturate at 2^CNT_W-1; no wrap.
- stall_run:
  - +1 (saturating) when stall & ~bubble.
  - Cleared to 0 on any edge without an effective stall, including a bubble edge.
- stall_timeout is registered: high in the cycle after stall_run reaches STALL_LIMIT. It falls on the edge where stall_run clears.
- clr_cnt=1 (without rst) zeroes all three counters on that edge; the increment in that cycle is discarded. The data path is unaffected.
- Counters are observation only and never feed back into the data path.
- Reset mid-stall: contents are lost and the bubble values are loaded; the next non-stalled edge loads normally.
- X on stall/bubble during rst=1 must not propagate to outputs.

Decomposition:
- Shared package pipe_pkg holds:
  - STAT_W.
  - Status encodings SAOK, SADR, SINS, SHLT.
  - Icode constants (IHALT=0, INOP=1, ...).
  - Packed-layout width constants for each stage payload (D_PAYLOAD_W=144, etc.).
  - Default BUBBLE_DATA per stage.
- One sub-module is natural: sat_counter (CNT_W, inc, clr, rst). Instantiate three times.

Test Plan:
- Reset and load: rst=1 for 2 cycles, then in_valid=1, in_stat=0, in_data=0x...AB. Required: outputs 0 during reset; out_data=0x...AB and out_valid=1 one cycle after the load edge.
- Stall hold: load A, then stall=1 for 5 cycles while in_data changes each cycle. Required: out_data stays A; stall_cnt=5; stall_run=5; after stall drops, next data loads and stall_run=0.
- Bubble priority: stall=1 and bubble=1 together with valid outputs present. Required: out_valid=0, out_stat=BUBBLE_STAT, out_data=BUBBLE_DATA; bubble_cnt+1; stall_cnt unchanged; stall_run=0.
- Watchdog: STALL_LIMIT=4, stall held for 6 cycles. Required: stall_timeout rises in the cycle after stall_run=4, stays high, and falls on the first non-stall edge.
- Saturation: CNT_W=3, stall held for 10 cycles. Required: stall_cnt and stall_run both stop at 7.
- clr_cnt and reset mid-stall: clr_cnt pulse during a stall gives counters 0 next cycle while data is held; rst during a stall gives bubble values with the held data lost.
